// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the oversampling UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 8;
    localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);

    localparam logic [TICK_W-1:0] SAMPLE_TICK_0 = TICK_W'(3);
    localparam logic [TICK_W-1:0] SAMPLE_TICK_1 = TICK_W'(4);
    localparam logic [TICK_W-1:0] SAMPLE_TICK_2 = TICK_W'(5);
    localparam logic [TICK_W-1:0] DECIDE_TICK   = TICK_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StWaitIdle
    } uart_state_e;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; push while full is accepted only with a pop.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [AW:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_level;
    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_empty   = (w_level == '0);
    assign w_full    = (w_level == FULL_LEVEL);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && !rst && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Head reads as zero when empty so tdata is 0 out of reset.
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_valid = !w_empty;
    assign o_full  = w_full;
    assign o_level = w_level;

endmodule

// File: rtl/uart_rx_os.sv
// 8x oversampling UART receiver with 2-of-3 bit voting and an AXI4-Stream output FIFO.
// Parity checking is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_os #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    input  logic [15:0]                   prescale,
    input  logic                          stop_bits,
    input  logic [1:0]                    parity_mode,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          overrun_error,
    output logic                          frame_error,
    output logic                          parity_error,
    output logic                          break_detect
);

    import uart_pkg::*;

    localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxd_prev;
    logic                   w_rxd;
    logic                   w_fall;

    uart_state_e            r_state;
    uart_state_e            w_state_next;

    logic [15:0]            r_prescale;
    logic [15:0]            r_pre_cnt;
    logic [15:0]            w_pre_last;
    logic [TICK_W-1:0]      r_tick;
    logic [2:0]             r_samples;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic                   r_all_zero;
    logic                   r_frame_err;
    logic                   r_stop_two;
    logic                   r_stop_idx;
    logic                   w_par_err;

    logic                   w_counting;
    logic                   w_tick_end;
    logic                   w_decide;
    logic                   w_vote;
    logic                   w_stop_err;
    logic                   w_start_frame;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_fifo_full;
    logic                   w_can_accept;
    logic                   w_frame_pulse;
    logic                   w_parity_pulse;
    logic                   w_break_pulse;
    logic                   w_overrun_pulse;

`ifdef UART_RX_PARITY_EN
    logic [1:0]             r_parity_mode;
    logic                   r_par_err;
    logic                   w_parity_on;
    logic                   w_par_expect;

    assign w_parity_on  = (r_parity_mode == 2'b01) || (r_parity_mode == 2'b10);
    assign w_par_expect = (r_parity_mode == 2'b10) ? ~^r_shift : ^r_shift;
    assign w_par_err    = r_par_err;
`else
    logic                   w_unused_parity;

    assign w_unused_parity = ^parity_mode;
    assign w_par_err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= '1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], rxd};
            r_rxd_prev <= w_rxd;
        end
    end

    assign w_rxd  = r_sync[SYNC_STAGES-1];
    assign w_fall = r_rxd_prev & ~w_rxd;

    // A latched prescale of 0 runs at the same rate as 1.
    assign w_pre_last = (r_prescale > 16'd1) ? (r_prescale - 16'd1) : 16'd0;
    assign w_counting = (r_state != StIdle) && (r_state != StWaitIdle);
    assign w_tick_end = w_counting && (r_pre_cnt == w_pre_last);
    assign w_decide   = w_tick_end && (r_tick == DECIDE_TICK);
    assign w_vote     = majority3(r_samples);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale <= '0;
            r_stop_two <= 1'b0;
            r_pre_cnt  <= '0;
            r_tick     <= '0;
            r_samples  <= '1;
        end else begin
            if (w_start_frame) begin
                r_prescale <= prescale;
                r_stop_two <= stop_bits;
                r_pre_cnt  <= '0;
                r_tick     <= '0;
            end else if (w_tick_end) begin
                r_pre_cnt  <= '0;
                r_tick     <= r_tick + 1'b1;
            end else if (w_counting) begin
                r_pre_cnt  <= r_pre_cnt + 16'd1;
            end
            if (w_tick_end && !w_start_frame) begin
                if (r_tick == SAMPLE_TICK_0) r_samples[0] <= w_rxd;
                if (r_tick == SAMPLE_TICK_1) r_samples[1] <= w_rxd;
                if (r_tick == SAMPLE_TICK_2) r_samples[2] <= w_rxd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_all_zero  <= 1'b1;
            r_frame_err <= 1'b0;
            r_stop_idx  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_mode <= 2'b00;
            r_par_err     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_start_frame) begin
                r_bit_cnt   <= '0;
                r_all_zero  <= 1'b1;
                r_frame_err <= 1'b0;
                r_stop_idx  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                r_parity_mode <= parity_mode;
                r_par_err     <= 1'b0;
`endif
            end else if (w_decide) begin
                case (r_state)
                    StData: begin
                        r_shift    <= {w_vote, r_shift[DATA_WIDTH-1:1]};
                        r_all_zero <= r_all_zero & ~w_vote;
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    StParity: begin
                        r_all_zero <= r_all_zero & ~w_vote;
                        r_par_err  <= (w_vote != w_par_expect);
                    end
`endif
                    StStop: begin
                        if (!w_vote) r_frame_err <= 1'b1;
                        r_stop_idx <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_pop        = m_axis_tvalid & m_axis_tready;
    assign w_can_accept = !w_fifo_full || w_pop;
    assign w_stop_err   = r_frame_err | ~w_vote;

    always_comb begin
        w_state_next    = r_state;
        w_start_frame   = 1'b0;
        w_push          = 1'b0;
        w_frame_pulse   = 1'b0;
        w_parity_pulse  = 1'b0;
        w_break_pulse   = 1'b0;
        w_overrun_pulse = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_fall) begin
                    w_state_next  = StStart;
                    w_start_frame = 1'b1;
                end
            end
            StStart: begin
                if (w_decide) w_state_next = w_vote ? StIdle : StData;
            end
            StData: begin
                if (w_decide && (r_bit_cnt == LAST_DATA_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_next = w_parity_on ? StParity : StStop;
`else
                    w_state_next = StStop;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (w_decide) w_state_next = StStop;
            end
`endif
            StStop: begin
                if (w_decide) begin
                    if (!r_stop_idx && r_all_zero && !w_vote) begin
                        w_break_pulse = 1'b1;
                        w_state_next  = StWaitIdle;
                    end else if (!r_stop_idx && r_stop_two) begin
                        w_state_next  = StStop;
                    end else begin
                        w_frame_pulse  = w_stop_err;
                        w_parity_pulse = w_par_err;
                        if (!w_stop_err && !w_par_err) begin
                            w_push          = w_can_accept;
                            w_overrun_pulse = !w_can_accept;
                        end
                        // The next start edge can coincide with the last stop decision.
                        if (w_fall) begin
                            w_state_next  = StStart;
                            w_start_frame = 1'b1;
                        end else begin
                            w_state_next  = StIdle;
                        end
                    end
                end
            end
            StWaitIdle: begin
                if (w_rxd) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
        if (rst) begin
            w_push          = 1'b0;
            w_frame_pulse   = 1'b0;
            w_parity_pulse  = 1'b0;
            w_break_pulse   = 1'b0;
            w_overrun_pulse = 1'b0;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (m_axis_tready),
        .o_data  (m_axis_tdata),
        .o_valid (m_axis_tvalid),
        .o_full  (w_fifo_full),
        .o_level (fifo_level)
    );

    assign busy          = (r_state != StIdle);
    assign overrun_error = w_overrun_pulse;
    assign frame_error   = w_frame_pulse;
    assign parity_error  = w_parity_pulse;
    assign break_detect  = w_break_pulse;

endmodule
